// File: rtl/alu_pkg.sv
// Shared opcode map and FSM encoding for the multicycle ALU.
// The control unit imports the same opcodes.
package alu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ADD   = 4'b0000;
  localparam opcode_t OP_SUB   = 4'b0001;
  localparam opcode_t OP_OR    = 4'b0010;
  localparam opcode_t OP_ORI   = 4'b0011;
  localparam opcode_t OP_SRL   = 4'b0100;
  localparam opcode_t OP_SLL   = 4'b0101;
  localparam opcode_t OP_LUI   = 4'b0110;
  localparam opcode_t OP_ANDI  = 4'b0111;
  localparam opcode_t OP_NOR   = 4'b1100;
  localparam opcode_t OP_AND   = 4'b1101;
  localparam opcode_t OP_MULTU = 4'b1110;
  localparam opcode_t OP_DIVU  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_multicycle_if.sv
// Issue/result bundle between the control unit (master) and the ALU (slave).
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic               start_i;
  logic [3:0]         alu_operation_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic [SHW-1:0]     shamt_i;
  logic [WIDTH/2-1:0] imm_i;
  logic               busy_o;
  logic               done_o;
  logic               zero_o;
  logic [WIDTH-1:0]   alu_data_o;
  logic [WIDTH-1:0]   hi_o;
  logic               div_by_zero_o;

  modport master (
    output start_i, alu_operation_i, a_i, b_i, shamt_i, imm_i,
    input  busy_o, done_o, zero_o, alu_data_o, hi_o, div_by_zero_o
  );

  modport slave (
    input  start_i, alu_operation_i, a_i, b_i, shamt_i, imm_i,
    output busy_o, done_o, zero_o, alu_data_o, hi_o, div_by_zero_o
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle engine: shift-add unsigned multiply and restoring unsigned divide.
// Exposes the post-iteration {hi, lo} so the caller can capture the final step directly.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             step_i,
  output logic             last_o,
  output logic [WIDTH-1:0] lo_d_o,
  output logic [WIDTH-1:0] hi_d_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             div_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0] sum, part, rem_sh, diff;
  logic           ge;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum    = {1'b0, hi_q} + {1'b0, m_q};
    part   = lo_q[0] ? sum : {1'b0, hi_q};
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, m_q};
    ge     = (rem_sh >= {1'b0, m_q});
    hi_d   = part[WIDTH:1];
    lo_d   = {part[0], lo_q[WIDTH-1:1]};
    if (div_q) begin
      hi_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (step_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the datapath registers carry no reset: they are always loaded at accept before being consumed.
  always_ff @(posedge clk) begin
    if (load_i) begin
      div_q <= div_i;
      m_q   <= div_i ? b_i : a_i;
      lo_q  <= div_i ? a_i : b_i;
      hi_q  <= '0;
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));
  assign lo_d_o = lo_d;
  assign hi_d_o = hi_d;

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle logic/arith/shift/immediate ops plus iterative MULTU/DIVU
// with a HI/LO result pair. The control unit stalls the PC while busy_o is high.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  alu_multicycle_if.slave  bus
);

  state_t state_q, state_d;

  logic             accept, is_mul, is_div, div_zero, iter_op, iter_last;
  logic [WIDTH-1:0] simple_res, imm_ext, iter_lo, iter_hi;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             zero_q, dbz_q;

  // DONE accepts a new op just like IDLE, so back-to-back issue costs no bubble.
  assign accept   = bus.start_i && (state_q != ST_CALC);
  assign is_mul   = (bus.alu_operation_i == OP_MULTU);
  assign is_div   = (bus.alu_operation_i == OP_DIVU);
  assign div_zero = is_div && (bus.b_i == '0);
  assign iter_op  = is_mul || (is_div && !div_zero);
  assign imm_ext  = {{(WIDTH/2){1'b0}}, bus.imm_i};

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept && iter_op),
    .div_i  (is_div),
    .a_i    (bus.a_i),
    .b_i    (bus.b_i),
    .step_i (state_q == ST_CALC),
    .last_o (iter_last),
    .lo_d_o (iter_lo),
    .hi_d_o (iter_hi)
  );

  always_comb begin
    simple_res = '0;
    case (bus.alu_operation_i)
      OP_ADD:  simple_res = bus.a_i + bus.b_i;
      OP_SUB:  simple_res = bus.a_i - bus.b_i;
      OP_OR:   simple_res = bus.a_i | bus.b_i;
      OP_ORI:  simple_res = bus.a_i | imm_ext;
      OP_SRL:  simple_res = bus.b_i >> bus.shamt_i;
      OP_SLL:  simple_res = bus.b_i << bus.shamt_i;
      OP_LUI:  simple_res = {bus.imm_i, {(WIDTH/2){1'b0}}};
      OP_ANDI: simple_res = bus.a_i & imm_ext;
      OP_NOR:  simple_res = ~(bus.a_i | bus.b_i);
      OP_AND:  simple_res = bus.a_i & bus.b_i;
      default: simple_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = iter_op ? ST_CALC : ST_DONE;
        else        state_d = ST_IDLE;
      end
      ST_CALC: if (iter_last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o = (state_q == ST_CALC);
    bus.done_o = (state_q == ST_DONE);
  end

  // Result registers move only at accept (single-cycle / DIVU by zero) or on the final iteration.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lo_q   <= '0;
      hi_q   <= '0;
      zero_q <= 1'b1;
      dbz_q  <= 1'b0;
    end else if (accept) begin
      if (div_zero) begin
        lo_q   <= '1;
        hi_q   <= bus.a_i;
        zero_q <= 1'b0;
        dbz_q  <= 1'b1;
      end else if (is_div) begin
        dbz_q  <= 1'b0;
      end else if (!is_mul) begin
        lo_q   <= simple_res;
        zero_q <= (simple_res == '0);
      end
    end else if (state_q == ST_CALC && iter_last) begin
      lo_q   <= iter_lo;
      hi_q   <= iter_hi;
      zero_q <= (iter_lo == '0);
    end
  end

  assign bus.alu_data_o    = lo_q;
  assign bus.hi_o          = hi_q;
  assign bus.zero_o        = zero_q;
  assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed cases plus random ops checked
// against an arithmetic reference model; a negedge monitor compares every done_o pulse.
module tb_alu_multicycle;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         zero;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int      tests = 0;
  int      fails = 0;
  exp_t    sb[$];
  exp_t    mon_e;
  logic [W-1:0] m_hi = '0;
  logic    m_dbz = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("alu_data_o", 64'(bus.alu_data_o), 64'(mon_e.lo));
        check("hi_o", 64'(bus.hi_o), 64'(mon_e.hi));
        check("zero_o", 64'(bus.zero_o), 64'(mon_e.zero));
        check("div_by_zero_o", 64'(bus.div_by_zero_o), 64'(mon_e.dbz));
      end
    end
  end

  // Drives one op for a single edge; the reference model predicts results from plain arithmetic.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] sh, input logic [15:0] imm, input bit push,
                      output int lat);
    exp_t e;
    logic [63:0] p;
    bus.start_i = 1'b1;
    bus.alu_operation_i = op;
    bus.a_i = a;
    bus.b_i = b;
    bus.shamt_i = sh;
    bus.imm_i = imm;
    lat = 1;
    e.hi = m_hi;
    e.dbz = m_dbz;
    case (op)
      4'b0000: e.lo = a + b;
      4'b0001: e.lo = a - b;
      4'b0010: e.lo = a | b;
      4'b0011: e.lo = a | {16'h0, imm};
      4'b0100: e.lo = b >> sh;
      4'b0101: e.lo = b << sh;
      4'b0110: e.lo = {imm, 16'h0};
      4'b0111: e.lo = a & {16'h0, imm};
      4'b1100: e.lo = ~(a | b);
      4'b1101: e.lo = a & b;
      4'b1110: begin
        p = {32'h0, a} * {32'h0, b};
        e.lo = p[31:0];
        e.hi = p[63:32];
        lat = W + 1;
      end
      4'b1111: begin
        if (b == 0) begin
          e.lo = '1;
          e.hi = a;
          e.dbz = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
          e.dbz = 1'b0;
          lat = W + 1;
        end
      end
      default: e.lo = '0;
    endcase
    e.zero = (e.lo == 0);
    if (push) begin
      sb.push_back(e);
      m_hi = e.hi;
      m_dbz = e.dbz;
    end
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  // Measures accept-to-done latency and busy_o cycles; optionally pulses an ADD at cycle 'inject'.
  task automatic wait_done(input string tag, input int exp_lat, input int inject);
    int lat;
    int busy;
    lat = 1;
    busy = 0;
    while (!bus.done_o && lat < 100) begin
      if (bus.busy_o) busy++;
      if (lat == inject) begin
        bus.start_i = 1'b1;
        bus.alu_operation_i = 4'b0000;
        bus.a_i = 32'd1;
        bus.b_i = 32'd1;
      end else begin
        bus.start_i = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start_i = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy), 64'(exp_lat - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int n_done;
    logic [3:0] op;
    logic [W-1:0] a, b;
    bus.start_i = 1'b0;
    bus.alu_operation_i = '0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.shamt_i = '0;
    bus.imm_i = '0;

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_data", 64'(bus.alu_data_o), 64'd0);
    check("rst_hi", 64'(bus.hi_o), 64'd0);
    check("rst_zero", 64'(bus.zero_o), 64'd1);
    check("rst_dbz", 64'(bus.div_by_zero_o), 64'd0);
    reset = 1'b1;

    send(4'b0000, 32'd5, 32'd7, 5'd0, 16'h0, 1'b1, lat);
    wait_done("add", 1, 0);

    send(4'b0001, 32'd9, 32'd9, 5'd0, 16'h0, 1'b1, lat);
    wait_done("sub", 1, 0);
    send(4'b0110, 32'd0, 32'd0, 5'd0, 16'h1234, 1'b1, lat);
    wait_done("lui_b2b", 1, 0);

    send(4'b1110, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 16'h0, 1'b1, lat);
    wait_done("multu_max", W + 1, 10);

    send(4'b1111, 32'd100, 32'd7, 5'd0, 16'h0, 1'b1, lat);
    wait_done("divu", W + 1, 0);
    send(4'b1111, 32'd5, 32'd0, 5'd0, 16'h0, 1'b1, lat);
    wait_done("divu_zero", 1, 0);

    // Abort a MULTU partway through; nothing is queued for it.
    send(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 16'h0, 1'b0, lat);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(bus.busy_o), 64'd0);
    check("abort_done", 64'(bus.done_o), 64'd0);
    check("abort_data", 64'(bus.alu_data_o), 64'd0);
    check("abort_hi", 64'(bus.hi_o), 64'd0);
    check("abort_zero", 64'(bus.zero_o), 64'd1);
    check("abort_dbz", 64'(bus.div_by_zero_o), 64'd0);
    m_hi = '0;
    m_dbz = 1'b0;
    reset = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done_o) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);

    send(4'b1110, 32'h0001_0000, 32'h0003_0000, 5'd0, 16'h0, 1'b1, lat);
    wait_done("multu_hi", W + 1, 0);
    send(4'b0101, 32'd0, 32'd1, 5'd31, 16'h0, 1'b1, lat);
    wait_done("sll31", 1, 0);
    send(4'b1010, 32'hDEAD_BEEF, 32'h1, 5'd3, 16'hFFFF, 1'b1, lat);
    wait_done("unlisted", 1, 0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      send(op, a, b, 5'($urandom), 16'($urandom), 1'b1, lat);
      wait_done("rand", lat, 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
